// File: rtl/alu_pipe_fwd_if.sv
// Instruction/result/read-back bundle for the forwarding ALU pipeline.
// The master side issues instructions and read-back addresses; the
// slave side (the pipeline) returns results, flags and memory data.
interface alu_pipe_fwd_if #(
    parameter int DW     = 16,
    parameter int REG_AW = 4,
    parameter int MEM_AW = 8
);
    // Instruction issue
    logic              in_valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [3:0]        func;
    logic [MEM_AW-1:0] addr;
    logic              st_en;

    // Result presented from the write-back stage
    logic [DW-1:0]     z;
    logic              out_valid;
    logic [REG_AW-1:0] out_rd;
    logic              flag_zero;
    logic              flag_carry;
    logic              out_err;

    // Data memory read-back port
    logic [MEM_AW-1:0] mem_raddr;
    logic [DW-1:0]     mem_rdata;

    modport master (
        output in_valid, rs1, rs2, rd, func, addr, st_en, mem_raddr,
        input  z, out_valid, out_rd, flag_zero, flag_carry, out_err, mem_rdata
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, func, addr, st_en, mem_raddr,
        output z, out_valid, out_rd, flag_zero, flag_carry, out_err, mem_rdata
    );
endinterface

// File: rtl/alu_pipe_fwd.sv
// Four-stage pipelined ALU with register bank, data memory and result
// forwarding.
//   S1: operand fetch from the bank
//   S2: operand forwarding + execute
//   S3: bank write-back, result/flags presented on the bus
//   S4: optional store of the result into the data memory
// One instruction per cycle, no stalls; dependent back-to-back
// instructions are resolved by forwarding from S2 and S3.
module alu_pipe_fwd #(
    parameter int DW     = 16,
    parameter int REG_AW = 4,
    parameter int MEM_AW = 8
) (
    input  logic              clk1,
    input  logic              rst,
    alu_pipe_fwd_if.slave     bus
);

    localparam int NREG  = 2 ** REG_AW;
    localparam int MDEPTH = 2 ** MEM_AW;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_PASSA = 4'd3,
        OP_PASSB = 4'd4,
        OP_AND   = 4'd5,
        OP_OR    = 4'd6,
        OP_XOR   = 4'd7,
        OP_NOTA  = 4'd8,
        OP_NOTB  = 4'd9,
        OP_SHR1  = 4'd10,
        OP_SHL1  = 4'd11,
        OP_LDI   = 4'd12
    } op_e;

    // Architectural state
    logic [DW-1:0]     bank [NREG];
    logic [DW-1:0]     mem  [MDEPTH];
    logic [DW-1:0]     rdata_q;

    // S1: fetched operands and decoded fields
    logic              s1_valid;
    logic [DW-1:0]     s1_a;
    logic [DW-1:0]     s1_b;
    logic [REG_AW-1:0] s1_rs1;
    logic [REG_AW-1:0] s1_rs2;
    logic [REG_AW-1:0] s1_rd;
    logic [3:0]        s1_func;
    logic [MEM_AW-1:0] s1_addr;
    logic              s1_st;

    // S2: executed result
    logic              s2_valid;
    logic [DW-1:0]     s2_result;
    logic [REG_AW-1:0] s2_rd;
    logic              s2_zero;
    logic              s2_carry;
    logic              s2_err;
    logic [MEM_AW-1:0] s2_addr;
    logic              s2_st;

    // S3: write-back / output stage
    logic              s3_valid;
    logic [DW-1:0]     s3_z;
    logic [REG_AW-1:0] s3_rd;
    logic              s3_zero;
    logic              s3_carry;
    logic              s3_err;
    logic [MEM_AW-1:0] s3_addr;
    logic              s3_st;

    // Execute-stage combinational values
    logic [DW-1:0]         op_a;
    logic [DW-1:0]         op_b;
    logic [DW-1:0]         alu_res;
    logic                  alu_carry;
    logic                  alu_err;
    logic [DW:0]           sum;
    logic [DW:0]           diff;
    logic [2*DW-1:0]       prod;
    logic [2*REG_AW-1:0]   imm;

    // S1: capture bank operands and instruction fields; ignore issue during reset
    always_ff @(posedge clk1) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_rd    <= '0;
            s1_func  <= '0;
            s1_addr  <= '0;
            s1_st    <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid;
            s1_a     <= bank[bus.rs1];
            s1_b     <= bank[bus.rs2];
            s1_rs1   <= bus.rs1;
            s1_rs2   <= bus.rs2;
            s1_rd    <= bus.rd;
            s1_func  <= bus.func;
            s1_addr  <= bus.addr;
            s1_st    <= bus.st_en;
        end
    end

    // Operand forwarding: S2 result is newest and overrides S3; illegal ops never write so never forward
    always_comb begin
        op_a = s1_a;
        op_b = s1_b;
        if (s3_valid && !s3_err && (s3_rd == s1_rs1)) op_a = s3_z;
        if (s3_valid && !s3_err && (s3_rd == s1_rs2)) op_b = s3_z;
        if (s2_valid && !s2_err && (s2_rd == s1_rs1)) op_a = s2_result;
        if (s2_valid && !s2_err && (s2_rd == s1_rs2)) op_b = s2_result;
    end

    // Execute: compute result, carry/borrow and illegal-opcode indication
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        sum       = {1'b0, op_a} + {1'b0, op_b};
        diff      = {1'b0, op_a} - {1'b0, op_b};
        prod      = {{DW{1'b0}}, op_a} * {{DW{1'b0}}, op_b};
        imm       = {s1_rs2, s1_rs1};
        case (s1_func)
            OP_ADD: begin
                alu_res   = sum[DW-1:0];
                alu_carry = sum[DW];
            end
            OP_SUB: begin
                alu_res   = diff[DW-1:0];
                alu_carry = diff[DW];
            end
            OP_MUL: begin
                alu_res   = prod[DW-1:0];
                alu_carry = |prod[2*DW-1:DW];
            end
            OP_PASSA: alu_res = op_a;
            OP_PASSB: alu_res = op_b;
            OP_AND:   alu_res = op_a & op_b;
            OP_OR:    alu_res = op_a | op_b;
            OP_XOR:   alu_res = op_a ^ op_b;
            OP_NOTA:  alu_res = ~op_a;
            OP_NOTB:  alu_res = ~op_b;
            OP_SHR1: begin
                alu_res   = op_a >> 1;
                alu_carry = op_a[0];
            end
            OP_SHL1: begin
                alu_res   = op_a << 1;
                alu_carry = op_a[DW-1];
            end
            OP_LDI:   alu_res = DW'(imm);
            default:  alu_err = 1'b1;
        endcase
    end

    // S2: register the executed result and flags
    always_ff @(posedge clk1) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_rd     <= '0;
            s2_zero   <= 1'b0;
            s2_carry  <= 1'b0;
            s2_err    <= 1'b0;
            s2_addr   <= '0;
            s2_st     <= 1'b0;
        end else begin
            s2_valid  <= s1_valid;
            s2_result <= alu_res;
            s2_rd     <= s1_rd;
            s2_zero   <= !alu_err && (alu_res == '0);
            s2_carry  <= alu_carry;
            s2_err    <= alu_err;
            s2_addr   <= s1_addr;
            s2_st     <= s1_st;
        end
    end

    // S3: present result; bubbles drop out_valid but hold result and flags
    always_ff @(posedge clk1) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_z     <= '0;
            s3_rd    <= '0;
            s3_zero  <= 1'b0;
            s3_carry <= 1'b0;
            s3_err   <= 1'b0;
            s3_addr  <= '0;
            s3_st    <= 1'b0;
        end else if (s2_valid) begin
            s3_valid <= 1'b1;
            s3_z     <= s2_result;
            s3_rd    <= s2_rd;
            s3_zero  <= s2_zero;
            s3_carry <= s2_carry;
            s3_err   <= s2_err;
            s3_addr  <= s2_addr;
            s3_st    <= s2_st && !s2_err;
        end else begin
            s3_valid <= 1'b0;
            s3_st    <= 1'b0;
        end
    end

    // Register bank: cleared on reset, written as an instruction enters S3
    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                bank[i] <= '0;
            end
        end else if (s2_valid && !s2_err) begin
            bank[s2_rd] <= s2_result;
        end
    end

    // S4 store: contents survive reset, but no store may land on a reset edge
    always_ff @(posedge clk1) begin
        if (!rst && s3_valid && s3_st) begin
            mem[s3_addr] <= s3_z;
        end
    end

    // Registered read-back: sees memory as it was before this edge's store
    always_ff @(posedge clk1) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[bus.mem_raddr];
        end
    end

    assign bus.z          = s3_z;
    assign bus.out_valid  = s3_valid;
    assign bus.out_rd     = s3_rd;
    assign bus.flag_zero  = s3_zero;
    assign bus.flag_carry = s3_carry;
    assign bus.out_err    = s3_err;
    assign bus.mem_rdata  = rdata_q;

endmodule

// File: tb/tb_alu_pipe_fwd.sv
// Self-checking bench for alu_pipe_fwd: instructions are applied against an
// architectural model (bank updated in program order), expected results are
// queued, and a monitor pops and compares whenever out_valid is seen.
module tb_alu_pipe_fwd;

    localparam int DW     = 16;
    localparam int REG_AW = 4;
    localparam int MEM_AW = 8;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;

    alu_pipe_fwd_if #(.DW(DW), .REG_AW(REG_AW), .MEM_AW(MEM_AW)) bus ();

    alu_pipe_fwd #(.DW(DW), .REG_AW(REG_AW), .MEM_AW(MEM_AW)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [15:0] z;
        logic [3:0]  rd;
        logic        zero;
        logic        carry;
        logic        err;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [15:0] mbank [16];
    logic [15:0] mmem  [256];
    bit          mwritten [256];
    logic [15:0] last_z = 16'h0;

    // Free-running cycle count used to check result latency
    always @(posedge clk1) cyc <= cyc + 1;

    // Architectural result of one instruction, using plain integer arithmetic
    function automatic void model(input int f, input longint a, input longint b,
                                  input int r1, input int r2,
                                  output longint zz, output bit cy, output bit er);
        zz = 0; cy = 1'b0; er = 1'b0;
        case (f)
            0:  begin zz = a + b; cy = (zz >= 65536); zz = zz % 65536; end
            1:  begin cy = (a < b); zz = (a - b + 65536) % 65536; end
            2:  begin zz = a * b; cy = (zz > 65535); zz = zz % 65536; end
            3:  zz = a;
            4:  zz = b;
            5:  zz = a & b;
            6:  zz = a | b;
            7:  zz = a ^ b;
            8:  zz = 65535 - a;
            9:  zz = 65535 - b;
            10: begin zz = a / 2; cy = ((a % 2) == 1); end
            11: begin zz = (a * 2) % 65536; cy = (a >= 32768); end
            12: zz = r2 * 16 + r1;
            default: er = 1'b1;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, expv);
        end
    endtask

    // Issue one instruction for one cycle and queue its expected result
    task automatic applyStimulus(input int f, input int d, input int s1, input int s2,
                                 input bit st, input int ad);
        longint zz;
        bit     cy;
        bit     er;
        exp_t   e;
        bus.in_valid = 1'b1;
        bus.func     = 4'(f);
        bus.rd       = 4'(d);
        bus.rs1      = 4'(s1);
        bus.rs2      = 4'(s2);
        bus.st_en    = st;
        bus.addr     = 8'(ad);
        model(f, longint'(mbank[s1]), longint'(mbank[s2]), s1, s2, zz, cy, er);
        e.z     = 16'(zz);
        e.rd    = 4'(d);
        e.zero  = !er && (zz == 0);
        e.carry = cy;
        e.err   = er;
        e.due   = cyc + 3;
        exp_q.push_back(e);
        if (!er) begin
            mbank[d] = 16'(zz);
            if (st) begin
                mmem[ad]     = 16'(zz);
                mwritten[ad] = 1'b1;
            end
        end
        @(posedge clk1); #1;
        bus.in_valid = 1'b0;
        bus.st_en    = 1'b0;
    endtask

    task automatic bubbles(input int n);
        bus.in_valid = 1'b0;
        bus.st_en    = 1'b0;
        repeat (n) begin @(posedge clk1); #1; end
    endtask

    // Wait (bounded) for all queued results, then confirm bubbles hold z
    task automatic drainPipe();
        int n = 0;
        bus.in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk1); #1;
            n++;
        end
        checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        bubbles(2);
        checkOutput("bubble_hold", 64'({bus.out_valid, bus.z}), 64'({1'b0, last_z}));
    endtask

    task automatic checkMem(input int ad, input logic [15:0] expv);
        bus.mem_raddr = 8'(ad);
        @(posedge clk1); #1;
        checkOutput("mem_rdata", 64'(bus.mem_rdata), 64'(expv));
    endtask

    // Monitor: every out_valid must match the oldest outstanding expectation
    always @(negedge clk1) begin
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("result",
                    64'({cyc, bus.z, bus.out_rd, bus.flag_zero, bus.flag_carry, bus.out_err}),
                    64'({mon_e.due, mon_e.z, mon_e.rd, mon_e.zero, mon_e.carry, mon_e.err}));
                last_z = mon_e.z;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) mbank[i] = 16'h0;
        for (int i = 0; i < 256; i++) mwritten[i] = 1'b0;
        bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.func = '0;
        bus.addr = '0; bus.st_en = 1'b0; bus.mem_raddr = '0;

        // Reset with an instruction presented; it must be ignored
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.func = 4'd12; bus.rd = 4'd3; bus.st_en = 1'b1; bus.addr = 8'h70;
        repeat (2) begin @(posedge clk1); #1; end
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.st_en = 1'b0;
        checkOutput("reset_state",
            64'({bus.z, bus.out_rd, bus.out_valid, bus.flag_zero, bus.flag_carry, bus.out_err, bus.mem_rdata}),
            64'd0);

        // LDI r1=0x12, LDI r2=0x05, ADD r3 with two bubbles between each
        applyStimulus(12, 1, 2, 1, 1'b0, 0);
        bubbles(2);
        applyStimulus(12, 2, 5, 0, 1'b0, 0);
        bubbles(2);
        applyStimulus(0, 3, 1, 2, 1'b0, 0);
        drainPipe();
        checkOutput("add_result_0x17", 64'(last_z), 64'h17);

        // Back-to-back dependencies through S2 and S3
        applyStimulus(12, 1, 15, 15, 1'b0, 0);
        applyStimulus(0, 1, 1, 1, 1'b0, 0);
        applyStimulus(1, 2, 1, 1, 1'b0, 0);
        drainPipe();

        // Shift chain, carry out of SHL1, overflowing MUL
        applyStimulus(12, 4, 15, 15, 1'b0, 0);
        repeat (8) applyStimulus(11, 4, 4, 0, 1'b0, 0);
        applyStimulus(11, 4, 4, 0, 1'b0, 0);
        applyStimulus(2, 5, 4, 4, 1'b0, 0);
        drainPipe();
        checkOutput("mul_low_zero", 64'(last_z), 64'h0);

        // Store timing and read-during-write returning old data
        applyStimulus(12, 6, 5, 5, 1'b1, 8'h3C);
        drainPipe();
        applyStimulus(12, 6, 2, 1, 1'b0, 0);
        applyStimulus(12, 7, 5, 0, 1'b0, 0);
        bus.mem_raddr = 8'h3C;
        applyStimulus(0, 8, 6, 7, 1'b1, 8'h3C);
        repeat (3) begin @(posedge clk1); #1; end
        checkOutput("mem_same_edge_old", 64'(bus.mem_rdata), 64'h55);
        @(posedge clk1); #1;
        checkOutput("mem_readback", 64'(bus.mem_rdata), 64'h17);
        drainPipe();

        // Illegal opcode leaves r1 untouched
        applyStimulus(12, 1, 2, 1, 1'b0, 0);
        applyStimulus(14, 1, 0, 0, 1'b1, 8'h3C);
        applyStimulus(3, 9, 1, 0, 1'b0, 0);
        drainPipe();
        checkMem(8'h3C, 16'h17);

        // Randomized instruction stream with random bubbles
        for (int i = 0; i < 300; i++) begin
            applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) == 0), 8'hC0 + int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) bubbles(int'($urandom_range(1, 3)));
        end
        drainPipe();
        for (int a = 8'hC0; a <= 8'hCF; a++) begin
            if (mwritten[a]) checkMem(a, mmem[a]);
        end

        // Reset mid-flight: no results, no stores, bank cleared
        applyStimulus(12, 10, 3, 3, 1'b1, 8'h70);
        applyStimulus(12, 11, 4, 4, 1'b1, 8'h71);
        drainPipe();
        bus.in_valid = 1'b1; bus.func = 4'd12; bus.rd = 4'd10; bus.rs1 = 4'hA; bus.rs2 = 4'hA;
        bus.st_en = 1'b1; bus.addr = 8'h70;
        @(posedge clk1); #1;
        bus.rd = 4'd11; bus.rs1 = 4'hB; bus.rs2 = 4'hB; bus.addr = 8'h71;
        @(posedge clk1); #1;
        rst = 1'b1;
        bus.rd = 4'd12; bus.addr = 8'h70;
        @(posedge clk1); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.st_en = 1'b0;
        for (int i = 0; i < 16; i++) mbank[i] = 16'h0;
        exp_q.delete();
        last_z = 16'h0;
        bubbles(6);
        checkOutput("no_out_after_reset", 64'(bus.out_valid), 64'd0);
        applyStimulus(3, 13, 10, 0, 1'b0, 0);
        applyStimulus(3, 14, 11, 0, 1'b0, 0);
        drainPipe();
        checkMem(8'h70, mmem[8'h70]);
        checkMem(8'h71, mmem[8'h71]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe_fwd.md
Name: alu_pipe_fwd

Overview:
- Parametrised single-clock, 4-stage pipelined ALU with a register bank and a data memory.
- Stages: S1 operand fetch, S2 execute, S3 register write-back and result output, S4 memory store.
- Improvements over the earlier two-phase ALU pipeline:
  - valid tracking and result forwarding, so dependent back-to-back instructions compute correctly;
  - status flags, an illegal-opcode indication, a load-immediate op, optional stores, and a memory read-back port.

Parameters:
- DW, 16, datapath width (≥ 8).
- REG_AW, 4, register index width; the bank holds 2**REG_AW registers.
- MEM_AW, 8, memory address width; memory depth is 2**MEM_AW words of DW bits.

Ports:
- clk1  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction present this cycle.
- rs1  in  REG_AW  source register A.
- rs2  in  REG_AW  source register B.
- rd  in  REG_AW  destination register.
- func  in  4  opcode.
- addr  in  MEM_AW  store address.
- st_en  in  1  instruction stores its result to memory.
- z  out  DW  result (S3).
- out_valid  out  1  z/out_rd/flags/out_err are valid.
- out_rd  out  REG_AW  destination register of the result.
- flag_zero  out  1  z == 0.
- flag_carry  out  1  carry/borrow/overflow-out (see below).
- out_err  out  1  illegal opcode.
- mem_raddr  in  MEM_AW  read-back address.
- mem_rdata  out  DW  read-back data, 1-cycle latency.

Behaviour:
- Pipeline timing. An instruction sampled at edge T (in_valid=1):
  - S1 at T: captures bank[rs1], bank[rs2], indices, rd, func, addr, st_en.
  - S2 at T+1: computes the result and flags.
  - S3 at T+2: writes bank[rd], drives z/out_valid.
  - S4 at T+3: writes mem[addr] if st_en.
  - Latency to out_valid is 3 cycles; throughput is 1 instruction per cycle; there is no stall.
- Bubbles. in_valid=0 inserts a bubble. A bubble never writes the bank or memory and produces out_valid=0. z and flags hold their last values.
- Forwarding, resolved in S2 per operand:
  - If S2 holds a valid instruction with rd == operand index, use its result (newest has priority).
  - Else if S3 holds a valid instruction with rd == operand index, use its result.
  - Else use the S1 captured value.
  - Distance ≥3 dependencies read the bank directly: the write lands before the read.
- Opcodes (A, B after forwarding, DW-bit unsigned):
  - 0 ADD: z = A+B; carry = carry out.
  - 1 SUB: z = A−B; carry = borrow (A<B).
  - 2 MUL: z = low DW of A*B; carry = OR of the high DW bits.
  - 3 PASSA: z = A.
  - 4 PASSB: z = B.
  - 5 AND, 6 OR, 7 XOR.
  - 8 NOTA, 9 NOTB.
  - 10 SHR1: carry = A[0].
  - 11 SHL1: carry = A[DW−1].
  - 12 LDI: z = zero-extended {rs2,rs1}, 2*REG_AW bits.
  - carry = 0 for ops 3–9 and 12.
  - 13–15 illegal: z = 0, out_err = 1, flags = 0, no bank write, no store; the instruction still produces out_valid=1.
- flag_zero reflects the final z, including for logic ops.
- Memory:
  - Synchronous write in S4.
  - mem_rdata is registered: mem[mem_raddr] as of before the edge. A simultaneous S4 write to the same address returns the old data.
  - Memory contents are not reset.
- Reset (rst=1 at an edge):
  - All stage valids cleared; in-flight instructions are discarded with no bank/mem writes on that edge or after.
  - All bank registers cleared to 0.
  - z=0, out_rd=0, out_valid=0, flag_zero=0, flag_carry=0, out_err=0, mem_rdata=0.
  - An in_valid asserted during reset is ignored.
- Writes to the same rd from S3 and reads in S1 on the same edge: S1 captures the old value and forwarding covers it.

Test Plan:
- After reset, LDI r1=0x12 (rs2=1, rs1=2), LDI r2=0x05, then ADD r3=r1+r2 with 2 bubbles between → z=0x0017, out_valid 3 cycles after each issue, flag_zero=0, flag_carry=0.
- Back-to-back LDI r1=0xFF, ADD r1=r1+r1, SUB r2=r1−r1, no bubbles → z=0x00FF, 0x01FE, then 0x0000 with flag_zero=1 (S2 and S3 forwarding exercised).
- LDI r4=0xFF; SHL1 ×8 chained on r4 → final z=0xFF00. Then SHL1 again → z=0xFE00, flag_carry=1. Then MUL r5=r4*r4 → z=0x0000, flag_carry=1.
- ADD with st_en=1, addr=0x3C producing 0x0017 → 4 cycles after issue, a read with mem_raddr=0x3C returns 0x0017 one cycle later. A read of the same address issued on the S4 write edge returns the old value.
- func=14 with rd=r1 holding 0x12 → out_valid=1, out_err=1, z=0; a later PASSA r1 returns 0x0012 (no write occurred).
- Issue 3 valid instructions, assert rst for 1 cycle mid-flight → no out_valid afterwards. PASSA of any register → 0. Store addresses untouched.
